// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised single-clock FIFO with a write/read handshake, registered read
// data, occupancy count, full/empty and programmable almost flags, a
// synchronous flush and sticky overflow/underflow error flags.
// The status flags are registered copies decoded from the next occupancy
// value, so they always match the count register and never depend
// combinationally on wr_en or rd_en.

module fifo_sync_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 1
) (
   input  logic                       CLK,
   input  logic                       aclr_n,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // Storage; contents are don't-care after reset
   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             wr_acc_s;
   logic             rd_acc_s;

   // Accept decisions; flush suppresses both requests
   always_comb begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
      if (flush) begin
         wr_acc_s = 1'b0;
         rd_acc_s = 1'b0;
      end else begin
         rd_acc_s = rd_en && !empty_q;
         // a same-cycle read frees the slot a write needs when full
         wr_acc_s = wr_en && (!full_q || rd_en);
      end
   end

   // Next-state computation for pointers, count, read data and error flags
   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      if (flush) begin
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
         rd_valid_d = 1'b0;
         ovf_d      = 1'b0;
         unf_d      = 1'b0;
      end else begin
         if (wr_acc_s) begin
            wptr_d = wptr_q + PTR_ONE;
         end else begin
            wptr_d = wptr_q;
         end
         if (rd_acc_s) begin
            rptr_d     = rptr_q + PTR_ONE;
            rd_data_d  = mem[rptr_q];
            rd_valid_d = 1'b1;
         end else begin
            rptr_d     = rptr_q;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         ovf_d = ovf_q | (wr_en & full_q & ~rd_en);
         unf_d = unf_q | (rd_en & empty_q);
      end
   end

   // Status flags decoded from the next occupancy so they track count exactly
   always_comb begin
      full_d   = 1'b0;
      empty_d  = 1'b1;
      afull_d  = 1'b0;
      aempty_d = 1'b1;
      full_d   = (count_d == DEPTH_C);
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= AF_C);
      aempty_d = (count_d <= AE_C);
   end

   // Control and status registers with asynchronous clear
   always_ff @(posedge CLK or negedge aclr_n) begin
      if (!aclr_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Storage write port; no reset so it maps onto plain RAM
   always_ff @(posedge CLK) begin
      if (wr_acc_s) begin
         mem[wptr_q] <= wr_data;
      end
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
// Drives fifo_sync_param (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1) through a
// sequence of directed and random cycles. A queue-based reference tracks the
// FIFO contents; words leaving it are pushed to a scoreboard and popped when
// the DUT presents rd_valid.

module tb_fifo_sync_param;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AFL   = 3;
   localparam int AEL   = 1;

   logic             CLK;
   logic             aclr_n;
   logic             flush;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [2:0]       count;
   logic             overflow;
   logic             underflow;

   fifo_sync_param #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AF_LEVEL(AFL),
      .AE_LEVEL(AEL)
   ) dut (
      .CLK         (CLK),
      .aclr_n      (aclr_n),
      .flush       (flush),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned      n_checks;
   int unsigned      n_errors;
   logic [WIDTH-1:0] model_q[$];
   logic [WIDTH-1:0] sb_q[$];
   logic             m_ovf;
   logic             m_unf;
   logic             m_rv;
   logic [WIDTH-1:0] m_rdata;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      int unsigned sz;
      sz = model_q.size();
      check_val({tag, " count"},        32'(count),        sz);
      check_val({tag, " full"},         32'(full),         32'(sz == DEPTH));
      check_val({tag, " empty"},        32'(empty),        32'(sz == 0));
      check_val({tag, " almost_full"},  32'(almost_full),  32'(sz >= AFL));
      check_val({tag, " almost_empty"}, 32'(almost_empty), 32'(sz <= AEL));
      check_val({tag, " overflow"},     32'(overflow),     32'(m_ovf));
      check_val({tag, " underflow"},    32'(underflow),    32'(m_unf));
      check_val({tag, " rd_valid"},     32'(rd_valid),     32'(m_rv));
      if (rd_valid) begin
         if (sb_q.size() == 0) begin
            check_val({tag, " sb_nonempty"}, 32'd0, 32'd1);
         end else begin
            check_val({tag, " rd_data"}, 32'(rd_data), 32'(sb_q.pop_front()));
         end
      end
      check_val({tag, " rd_data_held"}, 32'(rd_data), 32'(m_rdata));
   endtask

   // One clock cycle of stimulus with reference update, then sampled checks
   task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                       input logic f, input string tag);
      logic racc;
      logic wacc;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      flush   = f;
      if (f) begin
         model_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rv  = 1'b0;
      end else begin
         racc = r && (model_q.size() != 0);
         wacc = w && ((model_q.size() < DEPTH) || r);
         if (w && (model_q.size() == DEPTH) && !r) m_ovf = 1'b1;
         if (r && (model_q.size() == 0)) m_unf = 1'b1;
         m_rv = racc;
         if (racc) begin
            m_rdata = model_q.pop_front();
            sb_q.push_back(m_rdata);
         end
         if (wacc) model_q.push_back(d);
      end
      @(posedge CLK);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
      check_state(tag);
   endtask

   task automatic model_reset();
      model_q.delete();
      sb_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_rv    = 1'b0;
      m_rdata = '0;
   endtask

   initial begin
      logic [WIDTH-1:0] pat;
      n_checks = 0;
      n_errors = 0;
      aclr_n   = 1'b0;
      flush    = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wr_data  = '0;
      model_reset();

      // reset held for 9 ns
      #9;
      check_state("reset");
      aclr_n = 1'b1;
      @(posedge CLK);
      #1;
      check_state("post_release");

      // fill with walking ones, then overflow attempt
      pat = 8'h01;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, pat, 1'b0, 1'b0, "fill");
         pat = pat << 1;
      end
      step(1'b1, 8'h10, 1'b0, 1'b0, "overflow_wr");
      check_val("overflow_set", 32'(overflow), 32'd1);

      // drain, then underflow attempt
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      step(1'b0, 8'h00, 1'b1, 1'b0, "underflow_rd");
      check_val("underflow_rd_data", 32'(rd_data), 32'h08);
      check_val("underflow_set", 32'(underflow), 32'd1);

      // clear sticky flags before the wrap test
      step(1'b0, 8'h00, 1'b0, 1'b1, "flush1");

      // wrap-around: 6 writes interleaved with reads
      step(1'b1, 8'hA1, 1'b0, 1'b0, "wrap");
      step(1'b1, 8'hA2, 1'b0, 1'b0, "wrap");
      step(1'b1, 8'hA3, 1'b0, 1'b0, "wrap");
      step(1'b1, 8'hA4, 1'b1, 1'b0, "wrap");
      step(1'b1, 8'hA5, 1'b1, 1'b0, "wrap");
      step(1'b1, 8'hA6, 1'b0, 1'b0, "wrap");
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
      check_val("wrap_last", 32'(rd_data), 32'hA6);

      // simultaneous write+read when full
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, "fill2");
      step(1'b1, 8'hC0, 1'b1, 1'b0, "full_wr_rd");
      check_val("full_wr_rd_cnt", 32'(count), 32'd4);
      check_val("full_wr_rd_ovf", 32'(overflow), 32'd0);

      // overflow, drop to count 3, flush with a write pending
      step(1'b1, 8'hC1, 1'b0, 1'b0, "ovf2");
      step(1'b0, 8'h00, 1'b1, 1'b0, "to3");
      step(1'b1, 8'hC2, 1'b0, 1'b1, "flush_wr");
      check_val("flush_cnt", 32'(count), 32'd0);
      check_val("flush_ovf", 32'(overflow), 32'd0);

      // simultaneous write+read when empty
      step(1'b1, 8'hD0, 1'b1, 1'b0, "empty_wr_rd");
      check_val("empty_wr_rd_cnt", 32'(count), 32'd1);
      check_val("empty_wr_rd_unf", 32'(underflow), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, "empty_wr_rd_read");

      // random traffic
      for (int i = 0; i < 60; i++) begin
         step(1'(($urandom_range(0, 3) != 0)), 8'($urandom), 1'(($urandom_range(0, 1))),
              1'(($urandom_range(0, 19) == 0)), "rand");
      end

      // asynchronous reset mid-burst
      step(1'b1, 8'hE0, 1'b0, 1'b0, "burst");
      step(1'b1, 8'hE1, 1'b1, 1'b0, "burst");
      wr_en   = 1'b1;
      wr_data = 8'hE2;
      aclr_n  = 1'b0;
      #2;
      model_reset();
      check_state("async_reset");
      wr_en = 1'b0;
      #4;
      aclr_n = 1'b1;
      @(posedge CLK);
      #1;
      check_state("after_async");
      step(1'b1, 8'h5A, 1'b0, 1'b0, "resume");
      step(1'b0, 8'h00, 1'b1, 1'b0, "resume_rd");
      check_val("resume_data", 32'(rd_data), 32'h5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
